bitblaster_controller: RTL and testbench

// - Control sequencer upstream of the register file: latches a 10-bit instruction, steps T0..T2.
// - Drives register-file enables/addresses, ALU op, G-register load/drive and external/immediate bus drivers.
// - Shared bus: Q0, external data (Extrn) and G output (Gout) drive it, all tristate; it feeds reg-file D.
// - ALU A = Q0 bus, ALU B = Q1 bus; ImmOut drives the zero-extended immediate onto the B bus while ENR1=0.

---
 rtl/bitblaster_pkg.sv | 90 +++++++++
 rtl/bitblaster_ctrl_decode.sv | 78 +++++++
 rtl/bitblaster_controller.sv | 87 ++++++++
 tb/tb_bitblaster_controller.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bitblaster_pkg.sv
// ============================================================================
// Module : bitblaster_pkg
// Brief  : Shared types, field positions and opcode helpers for the bitblaster
//          control sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bitblaster_pkg;

    localparam int INSTR_W     = 10;
    localparam int REG_ADDR_W  = 2;
    localparam int IMM_FIELD_W = 4;

    localparam int OPC_MSB = 9;
    localparam int OPC_LSB = 6;
    localparam int RX_MSB  = 5;
    localparam int RX_LSB  = 4;
    localparam int RY_MSB  = 3;
    localparam int RY_LSB  = 2;

    typedef enum logic [3:0] {
        OP_LOAD = 4'b0000,
        OP_COPY = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0011,
        OP_NOT  = 4'b0100,
        OP_REV  = 4'b0101,
        OP_AND  = 4'b0110,
        OP_OR   = 4'b0111,
        OP_XOR  = 4'b1000,
        OP_ADDI = 4'b1001,
        OP_SUBI = 4'b1010
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_NOT = 4'd2,
        ALU_REV = 4'd3,
        ALU_AND = 4'd4,
        ALU_OR  = 4'd5,
        ALU_XOR = 4'd6
    } alu_op_t;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2
    } step_t;

    typedef struct packed {
        logic                  enw;
        logic [REG_ADDR_W-1:0] wra;
        logic                  enr0;
        logic [REG_ADDR_W-1:0] rda0;
        logic                  enr1;
        logic [REG_ADDR_W-1:0] rda1;
        logic                  extrn;
        logic                  imm_out;
        alu_op_t               alu;
        logic                  gin;
        logic                  gout;
        logic                  done;
    } ctrl_t;

    // Immediate forms reuse the plain ADD/SUB ALU codes.
    function automatic alu_op_t alu_of(input logic [3:0] op);
        case (op)
            OP_SUB, OP_SUBI: return ALU_SUB;
            OP_NOT:          return ALU_NOT;
            OP_REV:          return ALU_REV;
            OP_AND:          return ALU_AND;
            OP_OR:           return ALU_OR;
            OP_XOR:          return ALU_XOR;
            default:         return ALU_ADD;
        endcase
    endfunction

    function automatic logic is_two_step(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_NOT, OP_REV, OP_ADDI, OP_SUBI: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/bitblaster_ctrl_decode.sv
// ============================================================================
// Module : bitblaster_ctrl_decode
// Brief  : Pure combinational decode of (timestep, instruction fields) into
//          the register-file / ALU / bus control bundle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitblaster_ctrl_decode
    import bitblaster_pkg::*;
(
    input  step_t                 step,
    input  logic [3:0]            opcode,
    input  logic [REG_ADDR_W-1:0] rx,
    input  logic [REG_ADDR_W-1:0] ry,
    output ctrl_t                 ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (step)
            T1: begin
                case (opcode)
                    OP_LOAD: begin
                        ctrl.extrn = 1'b1;
                        ctrl.enw   = 1'b1;
                        ctrl.wra   = rx;
                        ctrl.done  = 1'b1;
                    end
                    OP_COPY: begin
                        ctrl.enr0 = 1'b1;
                        ctrl.rda0 = ry;
                        ctrl.enw  = 1'b1;
                        ctrl.wra  = rx;
                        ctrl.done = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        ctrl.enr0 = 1'b1;
                        ctrl.rda0 = rx;
                        ctrl.enr1 = 1'b1;
                        ctrl.rda1 = ry;
                        ctrl.alu  = alu_of(opcode);
                        ctrl.gin  = 1'b1;
                    end
                    OP_NOT, OP_REV: begin
                        ctrl.enr1 = 1'b1;
                        ctrl.rda1 = ry;
                        ctrl.alu  = alu_of(opcode);
                        ctrl.gin  = 1'b1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        // Read port 1 stays off so the immediate owns the B bus.
                        ctrl.enr0    = 1'b1;
                        ctrl.rda0    = rx;
                        ctrl.imm_out = 1'b1;
                        ctrl.alu     = alu_of(opcode);
                        ctrl.gin     = 1'b1;
                    end
                    default: begin
                        ctrl.done = 1'b1;
                    end
                endcase
            end
            T2: begin
                if (is_two_step(opcode)) begin
                    ctrl.gout = 1'b1;
                    ctrl.enw  = 1'b1;
                    ctrl.wra  = rx;
                    ctrl.done = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/bitblaster_controller.sv
// ============================================================================
// Module : bitblaster_controller
// Brief  : Instruction register plus T0..T2 step sequencer driving the
//          register file, ALU, G register and shared-bus drivers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitblaster_controller
    import bitblaster_pkg::*;
#(
    parameter int DATA_W = INSTR_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int IMM_W  = IMM_FIELD_W
) (
    input  logic              CLKb,
    input  logic              Clr,
    input  logic              Exec,
    input  logic [DATA_W-1:0] Instr,
    output logic              ENW,
    output logic [ADDR_W-1:0] WRA,
    output logic              ENR0,
    output logic [ADDR_W-1:0] RDA0,
    output logic              ENR1,
    output logic [ADDR_W-1:0] RDA1,
    output logic              Extrn,
    output logic              ImmOut,
    output logic [DATA_W-1:0] Imm,
    output logic [3:0]        ALUcont,
    output logic              Gin,
    output logic              Gout,
    output logic              Done,
    output logic              Busy,
    output logic [1:0]        Step
);

    step_t             state;
    logic [DATA_W-1:0] ir;
    ctrl_t             ctrl;

    // Exec is only looked at in T0, so a Done step always returns through
    // one idle T0 cycle before the next capture.
    always_ff @(posedge CLKb or posedge Clr) begin
        if (Clr) begin
            state <= T0;
            ir    <= '0;
        end else begin
            unique case (state)
                T0: begin
                    if (Exec) begin
                        ir    <= Instr;
                        state <= T1;
                    end
                end
                T1:      state <= ctrl.done ? T0 : T2;
                default: state <= T0;
            endcase
        end
    end

    bitblaster_ctrl_decode u_decode (
        .step   (state),
        .opcode (ir[OPC_MSB:OPC_LSB]),
        .rx     (ir[RX_MSB:RX_LSB]),
        .ry     (ir[RY_MSB:RY_LSB]),
        .ctrl   (ctrl)
    );

    assign ENW     = ctrl.enw;
    assign WRA     = ctrl.wra;
    assign ENR0    = ctrl.enr0;
    assign RDA0    = ctrl.rda0;
    assign ENR1    = ctrl.enr1;
    assign RDA1    = ctrl.rda1;
    assign Extrn   = ctrl.extrn;
    assign ImmOut  = ctrl.imm_out;
    assign ALUcont = ctrl.alu;
    assign Gin     = ctrl.gin;
    assign Gout    = ctrl.gout;
    assign Done    = ctrl.done;
    assign Imm     = {{(DATA_W-IMM_W){1'b0}}, ir[IMM_W-1:0]};
    assign Busy    = (state != T0);
    assign Step    = state;

endmodule

`default_nettype wire

// File: tb/tb_bitblaster_controller.sv
// ============================================================================
// Module : tb_bitblaster_controller
// Brief  : Self-checking bench for bitblaster_controller against an
//          opcode-table reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bitblaster_controller;

    logic       CLKb = 1'b0;
    logic       Clr  = 1'b0;
    logic       Exec = 1'b0;
    logic [9:0] Instr = '0;
    logic       ENW, ENR0, ENR1, Extrn, ImmOut, Gin, Gout, Done, Busy;
    logic [1:0] WRA, RDA0, RDA1, Step;
    logic [9:0] Imm;
    logic [3:0] ALUcont;

    int n_checks = 0;
    int n_errors = 0;

    // Per-opcode class: 0 load, 1 copy, 2 binary, 3 unary, 4 immediate, 5 nop
    int kind_tab [16] = '{0, 1, 2, 2, 3, 3, 2, 2, 2, 4, 4, 5, 5, 5, 5, 5};
    int alu_tab  [16] = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 0, 1, 0, 0, 0, 0, 0};

    int         m_step = 0;
    logic [9:0] m_ir   = '0;

    always #5 CLKb = ~CLKb;

    bitblaster_controller dut (
        .CLKb(CLKb), .Clr(Clr), .Exec(Exec), .Instr(Instr),
        .ENW(ENW), .WRA(WRA), .ENR0(ENR0), .RDA0(RDA0), .ENR1(ENR1), .RDA1(RDA1),
        .Extrn(Extrn), .ImmOut(ImmOut), .Imm(Imm), .ALUcont(ALUcont),
        .Gin(Gin), .Gout(Gout), .Done(Done), .Busy(Busy), .Step(Step)
    );

    logic [30:0] dut_vec;
    assign dut_vec = {ENW, WRA, ENR0, RDA0, ENR1, RDA1, Extrn, ImmOut, Imm,
                      ALUcont, Gin, Gout, Done, Busy, Step};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [30:0] model_vec(input int st, input logic [9:0] ir);
        logic       enw, enr0, enr1, extrn, immo, gin, gout, done;
        logic [1:0] wra, rda0, rda1, rx, ry;
        logic [3:0] alu;
        int         opc;
        {enw, enr0, enr1, extrn, immo, gin, gout, done} = '0;
        {wra, rda0, rda1} = '0;
        alu = '0;
        opc = int'(ir[9:6]);
        rx  = ir[5:4];
        ry  = ir[3:2];
        if (st == 1) begin
            case (kind_tab[opc])
                0: begin extrn = 1; enw = 1; wra = rx; done = 1; end
                1: begin enr0 = 1; rda0 = ry; enw = 1; wra = rx; done = 1; end
                2: begin enr0 = 1; rda0 = rx; enr1 = 1; rda1 = ry; gin = 1; alu = 4'(alu_tab[opc]); end
                3: begin enr1 = 1; rda1 = ry; gin = 1; alu = 4'(alu_tab[opc]); end
                4: begin enr0 = 1; rda0 = rx; immo = 1; gin = 1; alu = 4'(alu_tab[opc]); end
                default: done = 1;
            endcase
        end else if (st == 2) begin
            gout = 1; enw = 1; wra = rx; done = 1;
        end
        return {enw, wra, enr0, rda0, enr1, rda1, extrn, immo, {6'b0, ir[3:0]},
                alu, gin, gout, done, (st != 0), 2'(st)};
    endfunction

    task automatic model_edge(input logic e, input logic [9:0] ins);
        int k;
        k = kind_tab[int'(m_ir[9:6])];
        if (m_step == 0) begin
            if (e) begin m_ir = ins; m_step = 1; end
        end else if (m_step == 1) begin
            m_step = (k >= 2 && k <= 4) ? 2 : 0;
        end else begin
            m_step = 0;
        end
    endtask

    task automatic step_cycle(input string tag, input logic e, input logic [9:0] ins);
        Exec  = e;
        Instr = ins;
        @(posedge CLKb);
        model_edge(e, ins);
        #1;
        check_eq(tag, 32'(dut_vec), 32'(model_vec(m_step, m_ir)));
        check_eq("bus_excl", 32'($countones({ENR0, Extrn, Gout}) <= 1), 32'd1);
    endtask

    // Asynchronous clear raised mid-cycle; outputs must drop before any edge.
    task automatic do_clr();
        Exec = 1'b0;
        Clr  = 1'b1;
        m_step = 0;
        m_ir   = '0;
        #2;
        check_eq("clr_async", 32'(dut_vec), 32'd0);
        #2;
        Clr = 1'b0;
        @(posedge CLKb);
        #1;
        check_eq("clr_after", 32'(dut_vec), 32'(model_vec(m_step, m_ir)));
    endtask

    initial begin
        Clr = 1'b1;
        #12;
        check_eq("reset_state", 32'(dut_vec), 32'd0);
        Clr = 1'b0;
        @(posedge CLKb);
        #1;
        check_eq("idle", 32'(dut_vec), 32'(model_vec(m_step, m_ir)));

        // LOAD R2
        step_cycle("load_t1", 1'b1, 10'b0000_10_0000);
        check_eq("load_extrn", 32'({Extrn, ENW, WRA, Done}), 32'b1_1_10_1);
        step_cycle("load_t0", 1'b0, '0);
        check_eq("load_step", 32'(Step), 32'd0);

        // ADD R1,R3
        step_cycle("add_t1", 1'b1, 10'b0010_01_11_00);
        check_eq("add_t1_f", 32'({RDA0, RDA1, ALUcont, Gin}), {23'b0, 2'd1, 2'd3, 4'd0, 1'b1});
        step_cycle("add_t2", 1'b0, '0);
        check_eq("add_t2_f", 32'({Gout, ENW, WRA, Done}), 32'b1_1_01_1);
        step_cycle("add_t0", 1'b0, '0);

        // ADDI R0,15
        step_cycle("addi_t1", 1'b1, 10'b1001_00_1111);
        check_eq("addi_imm", 32'({ImmOut, Imm, ENR1, RDA0}), {19'b0, 1'b1, 10'd15, 1'b0, 2'd0});
        step_cycle("addi_t2", 1'b0, '0);
        check_eq("addi_wr", 32'({ENW, WRA}), 32'b1_00);
        step_cycle("addi_t0", 1'b0, '0);

        // Exec held high across two instructions
        step_cycle("hold_t1", 1'b1, 10'b0011_10_01_00);
        step_cycle("hold_t2", 1'b1, 10'b0000_11_0000);
        step_cycle("hold_t0", 1'b1, 10'b0000_11_0000);
        check_eq("hold_gap", 32'(Step), 32'd0);
        step_cycle("hold_next", 1'b1, 10'b0000_11_0000);
        check_eq("hold_cap", 32'({Extrn, WRA}), 32'b1_11);
        step_cycle("hold_end", 1'b0, '0);

        // NOP opcode 1111
        step_cycle("nop_t1", 1'b1, 10'b1111_11_1111);
        check_eq("nop_f", 32'({Done, ENW, ENR0, ENR1, Gin, Gout}), 32'b100000);
        step_cycle("nop_t0", 1'b0, '0);

        // SUB R3,R0 with Instr changing during T1/T2
        step_cycle("sub_t1", 1'b1, 10'b0011_11_00_00);
        step_cycle("sub_t2", 1'b1, 10'b0000_01_0000);
        check_eq("sub_wra", 32'({WRA, ENW}), 32'b11_1);
        step_cycle("sub_t0", 1'b1, 10'b0000_01_0000);

        // Clear in T1 of ADD
        step_cycle("clradd_t1", 1'b1, 10'b0010_10_01_00);
        do_clr();
        check_eq("clr_step", 32'({Step, ENW}), 32'd0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0)
                do_clr();
            else
                step_cycle("rand", 1'($urandom_range(0, 1)), 10'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
